// File: rtl/tpu_mac.sv
// Signed MAC processing element for a systolic array: forwards A/B, accumulates A*B into C.
// Latency: 1 cycle from Ain/Bin/Cin to Aout/Bout/Cout; a new MAC may issue every enabled cycle.
// Backpressure: none; en=0 freezes every register and ignores all data inputs.
module tpu_mac #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      WrEn,
  input  logic signed [BITS_AB-1:0] Ain,
  input  logic signed [BITS_AB-1:0] Bin,
  input  logic signed [BITS_C-1:0]  Cin,
  output logic signed [BITS_AB-1:0] Aout,
  output logic signed [BITS_AB-1:0] Bout,
  output logic signed [BITS_C-1:0]  Cout
);

  // Full-precision product of the live inputs (not the forwarded copies).
  logic signed [2*BITS_AB-1:0] prod;
  logic signed [BITS_C-1:0]    prod_ext;

  assign prod     = Ain * Bin;
  // Signed size cast sign-extends; also works when BITS_C == 2*BITS_AB.
  assign prod_ext = BITS_C'(prod);

  // Operand forwarding and accumulate/preload; reset wins over en and WrEn.
  always_ff @(posedge clk) begin
    if (rst) begin
      Aout <= '0;
      Bout <= '0;
      Cout <= '0;
    end else if (en) begin
      Aout <= Ain;
      Bout <= Bin;
      if (WrEn) Cout <= Cin;
      else      Cout <= Cout + prod_ext;  // wraps modulo 2^BITS_C
    end
  end

endmodule

// File: tb/tb_tpu_mac.sv
// Directed bench for tpu_mac: reset, preload, accumulate, hold, wrap and mid-run reset.
// Inputs are driven with blocking assignments; outputs are sampled 1 time unit after the edge.
// Expected values come from hand-computed constants and a small signed reference model.
`timescale 1ns/1ps
module tb_tpu_mac;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               WrEn;
  logic signed [7:0]  Ain;
  logic signed [7:0]  Bin;
  logic signed [15:0] Cin;
  logic signed [7:0]  Aout;
  logic signed [7:0]  Bout;
  logic signed [15:0] Cout;

  int total = 0;
  int bad   = 0;

  // Reference state
  logic signed [7:0]  ma;
  logic signed [7:0]  mb;
  logic signed [15:0] mc;

  tpu_mac #(.BITS_AB(8), .BITS_C(16)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .WrEn(WrEn),
    .Ain (Ain),
    .Bin (Bin),
    .Cin (Cin),
    .Aout(Aout),
    .Bout(Bout),
    .Cout(Cout)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Compare all three outputs against the reference model.
  task automatic chk_all(input string tag);
    chk({tag, ".a"}, int'(Aout), int'(ma));
    chk({tag, ".b"}, int'(Bout), int'(mb));
    chk({tag, ".c"}, int'(Cout), int'(mc));
  endtask

  // One clock with given controls/data; updates the reference model.
  task automatic step(input logic e, input logic w, input logic signed [7:0] a,
                      input logic signed [7:0] b, input logic signed [15:0] c);
    logic signed [15:0] p;
    rst = 1'b0; en = e; WrEn = w; Ain = a; Bin = b; Cin = c;
    @(posedge clk);
    #1;
    if (e) begin
      p  = 16'(a) * 16'(b);
      mc = w ? c : mc + p;
      ma = a;
      mb = b;
    end
  endtask

  task automatic idle_random();
    step(1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 16'($urandom));
  endtask

  initial begin
    ma = '0; mb = '0; mc = '0;
    en = 1'b0; WrEn = 1'b0; Ain = '0; Bin = '0; Cin = '0;

    // 1: reset for two cycles, then hold at zero with en=0
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst.a", int'(Aout), 0);
    chk("rst.b", int'(Bout), 0);
    chk("rst.c", int'(Cout), 0);
    for (int i = 0; i < 4; i++) begin
      idle_random();
      chk_all("rst_hold");
    end

    // 2: preload A=3, B=-2, C=100, then hold with unknown inputs
    step(1'b1, 1'b1, 8'sd3, -8'sd2, 16'sd100);
    chk("load.a", int'(Aout), 3);
    chk("load.b", int'(Bout), -2);
    chk("load.c", int'(Cout), 100);
    en = 1'b0; WrEn = 1'bx; Ain = 'x; Bin = 'x; Cin = 'x;
    repeat (2) @(posedge clk);
    #1;
    chk("load_hold.a", int'(Aout), 3);
    chk("load_hold.b", int'(Bout), -2);
    chk("load_hold.c", int'(Cout), 100);

    // 3: accumulate 5*7 onto 100 -> 135, then hold
    step(1'b1, 1'b0, 8'sd5, 8'sd7, 16'sd0);
    chk("mac.a", int'(Aout), 5);
    chk("mac.b", int'(Bout), 7);
    chk("mac.c", int'(Cout), 135);
    step(1'b0, 1'b0, 8'sd9, 8'sd9, 16'sd0);
    chk("mac_hold.c", int'(Cout), 135);
    chk("mac_hold.a", int'(Aout), 5);

    // 4: random accumulation runs interleaved with idle cycles
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(15, 1);
      for (int i = 0; i < n; i++) begin
        step(1'b1, 1'b0, 8'($urandom), 8'($urandom), 16'($urandom));
        chk_all("acc");
        idle_random();
        chk_all("acc_idle");
      end
    end

    // 5: overflow wrap and most-negative product
    step(1'b1, 1'b1, 8'sd0, 8'sd0, 16'sd32767);
    chk("wrap_pre.c", int'(Cout), 32767);
    step(1'b1, 1'b0, 8'sd1, 8'sd1, 16'sd0);
    chk("wrap.c", int'(Cout), -32768);
    step(1'b1, 1'b1, 8'sd0, 8'sd0, 16'sd0);
    chk("neg_pre.c", int'(Cout), 0);
    step(1'b1, 1'b0, -8'sd128, -8'sd128, 16'sd0);
    chk("negneg.c", int'(Cout), 16384);
    chk("negneg.a", int'(Aout), -128);

    // 6: reset during accumulation beats en/WrEn, then restart from 0
    step(1'b1, 1'b0, 8'sd10, 8'sd10, 16'sd0);
    chk("pre_rst.c", int'(Cout), 16484);
    rst = 1'b1; en = 1'b1; WrEn = 1'b0; Ain = 8'sd4; Bin = 8'sd4; Cin = 16'sd55;
    @(posedge clk);
    #1;
    ma = '0; mb = '0; mc = '0;
    chk("mid_rst.a", int'(Aout), 0);
    chk("mid_rst.b", int'(Bout), 0);
    chk("mid_rst.c", int'(Cout), 0);
    step(1'b1, 1'b0, -8'sd6, 8'sd7, 16'sd0);
    chk("restart.c", int'(Cout), -42);
    step(1'b1, 1'b0, 8'sd2, 8'sd3, 16'sd0);
    chk("restart2.c", int'(Cout), -36);
    chk_all("restart2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
